dht11_sensor_emu: RTL and testbench
===================================

// Module: dht11_sensor_emu
// PURPOSE
//  Synthesizable DHT11 sensor model: the responder end of the DHT11 single-wire bus.
//  - Detects the host start pulse, then sends the response preamble and a 40-bit frame
//    (RH int, RH dec, T int, T dec, checksum) built from register inputs.
//  - Used for on-board loopback against the DHT11 host driver and as a bench model.
// PARAMETERS
//  CLK_FREQ_HZ    100_000_000  system clock; one microsecond = CLK_FREQ_HZ/1_000_000 clocks
//  START_MIN_US   18000        minimum host low time accepted as a start signal
//  RESP_DLY_US    30           release-to-response gap (DHT11 spec 20-40us)
//  RESP_LOW_US    80           response low phase
//  RESP_HIGH_US   80           response high (released) phase
//  BIT_LOW_US     50           low preamble before each data bit and final end-low
//  BIT0_HIGH_US   26           released high time encoding '0'
//  BIT1_HIGH_US   70           released high time encoding '1'
// PORTS
//  clk              in     1  system clock
//  rst              in     1  asynchronous active-high reset
//  rh_int           in     8  humidity integer byte (frame byte 0, MSB first)
//  rh_dec           in     8  humidity decimal byte
//  t_int            in     8  temperature integer byte
//  t_dec            in     8  temperature decimal byte
//  inject_cksum_err in     1  1: transmit checksum XOR 8'h01 (fault injection)
//  busy             out    1  high from start accepted until the bus is released after end-low
//  frame_done       out    1  one-clock pulse when the final end-low completes
//  dht11_io         inout  1  open-drain bus: drive 1'b0 or 1'bz only, never drive 1
// BEHAVIOUR
//  Reset (async): state IDLE, bus released (z), busy=0, frame_done=0, all counters 0.
//  Reset mid-frame: bus released immediately; no partial frame is resumed.
//  Bus input: 2-flop synchronizer on dht11_io; all decisions use the synced value.
//  Timebase:
//   - 1us tick prescaler, cleared on every state transition.
//   - Each driven or released phase lasts exactly N*CLK_PER_US clocks.
//  FSM:
//   - IDLE:      wait for a synced falling edge (high then low); clear the us counter -> HOST_LOW.
//   - HOST_LOW:  count us while the line is low. On a synced rising edge: count >= START_MIN_US
//                -> RESP_DLY; otherwise -> IDLE (pulse ignored). The counter saturates and never wraps.
//   - RESP_DLY:  released for RESP_DLY_US -> RESP_LOW.
//                On this transition, latch shift register = {rh_int, rh_dec, t_int, t_dec, cksum}.
//   - RESP_LOW:  drive 0 for RESP_LOW_US -> RESP_HIGH.
//   - RESP_HIGH: release for RESP_HIGH_US -> BIT_LOW.
//   - BIT_LOW:   drive 0 for BIT_LOW_US -> BIT_HIGH.
//   - BIT_HIGH:  release for BIT1_HIGH_US if the shift-register MSB is 1, else BIT0_HIGH_US.
//                Then shift left and increment bit_cnt. bit_cnt==39 -> END_LOW, else -> BIT_LOW.
//   - END_LOW:   drive 0 for BIT_LOW_US; pulse frame_done; release -> IDLE.
//  Checksum and data latching:
//   - cksum = (rh_int+rh_dec+t_int+t_dec) mod 256, then XOR 8'h01 if inject_cksum_err.
//   - inject_cksum_err is sampled at the same latch point as the data.
//   - Data inputs changing after the latch point do not affect the frame in flight.
//  Line handling:
//   - Line activity is ignored from RESP_DLY through END_LOW.
//   - Re-arm needs the line seen high in IDLE, so a host holding the line low after
//     END_LOW does not retrigger.
//  busy = (state != IDLE && state != HOST_LOW).
// STRUCTURE
//  - Include file dht11_defs.vh: timing defaults shared with the host driver, frame width 40,
//    state encodings.
//  - Sub-module us_tick_gen (CLK_FREQ_HZ, synchronous clear input) supplies the 1us tick.
//  - Top level holds the FSM, us counter, bit_cnt, 40-bit shift register and synchronizer.
// TESTING (bench puts a pullup on dht11_io; START_MIN_US=1000 to shorten simulation)
//  - Host drives low 1900us, drives high 20us, releases; data 37/00/19/00
//    -> after 30us: 80us low, 80us high, 40 bits of 0x37_00_19_00_50 (50us low + 26/70us high), 50us end-low.
//  - Host low 500us, then released -> no response; bus stays z, busy stays 0.
//  - Data 37/00/19/00 with inject_cksum_err=1 -> checksum byte on wire is 0x51.
//  - rst asserted during bit 20 low phase -> bus z in the same cycle, busy=0; next valid start gives a full frame.
//  - Change rh_int 0x37 -> 0x42 during bit 5 -> frame still carries 0x37 and checksum 0x50.
//  - Loopback with the DHT11 host driver (start pulse) -> dht11_done=1, rh_data=0x37, t_data=0x19.

Source files
------------

// File: rtl/dht11_sensor_emu_pkg.sv
// DHT11 responder shared definitions: timing defaults shared with the host driver,
// frame geometry, FSM state encoding and the frame checksum helper.
package dht11_sensor_emu_pkg;

  // Timing defaults in microseconds, shared with the DHT11 host driver.
  localparam int unsigned DefClkFreqHz  = 100_000_000;
  localparam int unsigned DefStartMinUs = 18000;
  localparam int unsigned DefRespDlyUs  = 30;
  localparam int unsigned DefRespLowUs  = 80;
  localparam int unsigned DefRespHighUs = 80;
  localparam int unsigned DefBitLowUs   = 50;
  localparam int unsigned DefBit0HighUs = 26;
  localparam int unsigned DefBit1HighUs = 70;

  // Frame: RH int, RH dec, T int, T dec, checksum; MSB first on the wire.
  localparam int unsigned FrameBits = 40;
  localparam int unsigned BitCntW   = 6;
  // Microsecond counter; wide enough for an 18 ms start pulse, saturates at all-ones.
  localparam int unsigned UsCntW    = 16;

  typedef enum logic [2:0] {
    StIdle,
    StHostLow,
    StRespDly,
    StRespLow,
    StRespHigh,
    StBitLow,
    StBitHigh,
    StEndLow
  } dht_state_e;

  // Byte sum mod 256, optionally corrupted in bit 0 for fault injection.
  function automatic logic [7:0] dht_cksum(input logic [7:0] rh_i, input logic [7:0] rd_i,
                                           input logic [7:0] ti_i, input logic [7:0] td_i,
                                           input logic inj_i);
    logic [7:0] sum;
    sum = rh_i + rd_i + ti_i + td_i;
    return sum ^ {7'd0, inj_i};
  endfunction

endpackage

// File: rtl/dht11_sensor_emu_us_tick_gen.sv
// us_tick_gen: one-clock tick every microsecond.
//  clk    in  system clock
//  rst    in  asynchronous active-high reset
//  clear  in  synchronous restart of the prescaler (tick phase realigned to the next clock)
//  tick   out high on the last clock of each microsecond
module us_tick_gen #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned ClkPerUs = (CLK_FREQ_HZ / 1_000_000 > 0) ? CLK_FREQ_HZ / 1_000_000 : 1;
  localparam int unsigned CntW     = (ClkPerUs > 1) ? $clog2(ClkPerUs) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(ClkPerUs - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dht11_sensor_emu.sv
// dht11_sensor_emu: responder end of the DHT11 single-wire bus.
// Detects a host start pulse, then sends the response preamble and a 40-bit frame
// {rh_int, rh_dec, t_int, t_dec, checksum} latched from the register inputs.
//  clk, rst           system clock, asynchronous active-high reset
//  rh_int .. t_dec    frame data bytes
//  inject_cksum_err   1: transmit checksum XOR 8'h01
//  busy               high from start accepted until the bus is released after end-low
//  frame_done         one-clock pulse as the final end-low completes
//  dht11_io           open-drain bus, driven 0 or released (z) only
module dht11_sensor_emu #(
  parameter int unsigned CLK_FREQ_HZ  = dht11_sensor_emu_pkg::DefClkFreqHz,
  parameter int unsigned START_MIN_US = dht11_sensor_emu_pkg::DefStartMinUs,
  parameter int unsigned RESP_DLY_US  = dht11_sensor_emu_pkg::DefRespDlyUs,
  parameter int unsigned RESP_LOW_US  = dht11_sensor_emu_pkg::DefRespLowUs,
  parameter int unsigned RESP_HIGH_US = dht11_sensor_emu_pkg::DefRespHighUs,
  parameter int unsigned BIT_LOW_US   = dht11_sensor_emu_pkg::DefBitLowUs,
  parameter int unsigned BIT0_HIGH_US = dht11_sensor_emu_pkg::DefBit0HighUs,
  parameter int unsigned BIT1_HIGH_US = dht11_sensor_emu_pkg::DefBit1HighUs
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rh_int,
  input  logic [7:0] rh_dec,
  input  logic [7:0] t_int,
  input  logic [7:0] t_dec,
  input  logic       inject_cksum_err,
  output logic       busy,
  output logic       frame_done,
  inout  wire        dht11_io
);

  import dht11_sensor_emu_pkg::*;

  localparam logic [UsCntW-1:0] StartMin  = UsCntW'(START_MIN_US);
  localparam logic [UsCntW-1:0] RespDly   = UsCntW'(RESP_DLY_US);
  localparam logic [UsCntW-1:0] RespLow   = UsCntW'(RESP_LOW_US);
  localparam logic [UsCntW-1:0] RespHigh  = UsCntW'(RESP_HIGH_US);
  localparam logic [UsCntW-1:0] BitLow    = UsCntW'(BIT_LOW_US);
  localparam logic [UsCntW-1:0] Bit0High  = UsCntW'(BIT0_HIGH_US);
  localparam logic [UsCntW-1:0] Bit1High  = UsCntW'(BIT1_HIGH_US);
  localparam logic [BitCntW-1:0] LastBit  = BitCntW'(FrameBits - 1);

  dht_state_e state_q, state_d;

  logic                 sync1_q, sync2_q, line_prev_q;
  logic [UsCntW-1:0]    us_cnt_q, us_cnt_d;
  logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [FrameBits-1:0] shreg_q, shreg_d;
  logic                 frame_done_q, frame_done_d;
  logic [UsCntW-1:0]    phase_len;
  logic                 tick, phase_end, state_chg;
  logic                 line_fall, line_rise, drive_low;

  // Synchronizer resets low so a line that is already low when reset releases cannot
  // look like a falling edge; the line must first be seen high to arm.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      line_prev_q <= 1'b0;
    end else begin
      sync1_q     <= dht11_io;
      sync2_q     <= sync1_q;
      line_prev_q <= sync2_q;
    end
  end

  assign line_fall = line_prev_q & ~sync2_q;
  assign line_rise = ~line_prev_q & sync2_q;

  assign state_chg = (state_d != state_q);

  us_tick_gen #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(state_chg),
    .tick (tick)
  );

  // Length of the current timed phase in microseconds.
  always_comb begin
    phase_len = '0;
    unique case (state_q)
      StRespDly:  phase_len = RespDly;
      StRespLow:  phase_len = RespLow;
      StRespHigh: phase_len = RespHigh;
      StBitLow:   phase_len = BitLow;
      StEndLow:   phase_len = BitLow;
      StBitHigh:  phase_len = shreg_q[FrameBits-1] ? Bit1High : Bit0High;
      default:    phase_len = '0;
    endcase
  end

  // Last clock of the phase: prescaler wraps while the counter holds N-1.
  assign phase_end = tick && (us_cnt_q == phase_len - 1'b1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (line_fall) state_d = StHostLow;
      end
      StHostLow: begin
        if (line_rise) state_d = (us_cnt_q >= StartMin) ? StRespDly : StIdle;
      end
      StRespDly: begin
        if (phase_end) state_d = StRespLow;
      end
      StRespLow: begin
        if (phase_end) state_d = StRespHigh;
      end
      StRespHigh: begin
        if (phase_end) state_d = StBitLow;
      end
      StBitLow: begin
        if (phase_end) state_d = StBitHigh;
      end
      StBitHigh: begin
        if (phase_end) state_d = (bit_cnt_q == LastBit) ? StEndLow : StBitLow;
      end
      StEndLow: begin
        if (phase_end) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    us_cnt_d     = us_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    frame_done_d = 1'b0;

    if (state_chg || state_q == StIdle) begin
      us_cnt_d = '0;
    end else if (tick && us_cnt_q != '1) begin
      us_cnt_d = us_cnt_q + 1'b1;
    end

    // Data and fault-injection flag are captured once, at the start of the response.
    if (state_q == StRespDly && state_d == StRespLow) begin
      shreg_d   = {rh_int, rh_dec, t_int, t_dec,
                   dht_cksum(rh_int, rh_dec, t_int, t_dec, inject_cksum_err)};
      bit_cnt_d = '0;
    end

    if (state_q == StBitHigh && state_chg) begin
      shreg_d   = {shreg_q[FrameBits-2:0], 1'b0};
      bit_cnt_d = bit_cnt_q + 1'b1;
    end

    if (state_q == StEndLow && state_chg) begin
      frame_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      us_cnt_q     <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      us_cnt_q     <= us_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Decoded straight from the state register so reset releases the bus without waiting a clock.
  assign drive_low  = (state_q == StRespLow) || (state_q == StBitLow) || (state_q == StEndLow);
  assign dht11_io   = drive_low ? 1'b0 : 1'bz;
  assign busy       = (state_q != StIdle) && (state_q != StHostLow);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_dht11_sensor_emu.sv
module tb_dht11_sensor_emu;

  localparam int unsigned ClkHz = 2_000_000;
  localparam int P = 2;  // clocks per microsecond
  localparam int RespDlyCyc = 30 * P;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rh_int = 8'h00, rh_dec = 8'h00, t_int = 8'h00, t_dec = 8'h00;
  logic       inject = 1'b0;
  logic       busy, frame_done;
  logic       host_en = 1'b0, host_val = 1'b1;
  wire        bus;

  pullup (bus);
  assign bus = host_en ? host_val : 1'bz;

  always #5 clk = ~clk;

  dht11_sensor_emu #(
    .CLK_FREQ_HZ (ClkHz),
    .START_MIN_US(1000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rh_int          (rh_int),
    .rh_dec          (rh_dec),
    .t_int           (t_int),
    .t_dec           (t_dec),
    .inject_cksum_err(inject),
    .busy            (busy),
    .frame_done      (frame_done),
    .dht11_io        (bus)
  );

  // ---------------- bench state ----------------
  int n_cmp = 0, n_bad = 0;
  // written by stimulus only
  logic [39:0] arm_bytes = '0;
  int          arm_req = 0, tmo_req = 0;
  logic        quiet = 1'b0, lit_valid = 1'b0;
  logic [39:0] lit_exp = '0;
  // written by compare process only
  int          arm_seen = 0, tmo_seen = 0, pos = 0, frames_done = 0, busy_run = 0;
  int          hi_run = 0, hi_cnt = 0;
  logic        armed = 1'b0, in_frame = 1'b0, end_slot = 1'b0, rst_seen = 1'b0;
  logic        pinned = 1'b0;
  logic [39:0] exp_bytes = '0, wire_bits = '0;
  bit          exp_q[$];

  // ---------------- behavioural model ----------------
  function automatic logic [39:0] frame_of(logic [7:0] a, logic [7:0] b, logic [7:0] c,
                                           logic [7:0] d, logic inj);
    int s;
    logic [7:0] k;
    s = (int'(a) + int'(b) + int'(c) + int'(d)) % 256;
    k = 8'(s);
    if (inj) k = k ^ 8'h01;
    return {a, b, c, d, k};
  endfunction

  // Cycle offset (from first response low) at which bit k's low preamble starts.
  function automatic int bit_start(logic [39:0] f, int k);
    int c;
    c = 160;
    for (int i = 0; i < k; i++) c += 50 + (f[39-i] ? 70 : 26);
    return c * P;
  endfunction

  task automatic push_level(bit v, int us);
    for (int i = 0; i < us * P; i++) exp_q.push_back(v);
  endtask

  task automatic build_wave(logic [39:0] f);
    exp_q.delete();
    push_level(1'b0, 80);
    push_level(1'b1, 80);
    for (int i = 39; i >= 0; i--) begin
      push_level(1'b0, 50);
      push_level(1'b1, f[i] ? 70 : 26);
    end
    push_level(1'b0, 50);
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  initial begin
    logic [39:0] f;
    bit e;
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        if (!rst_seen) #1;
        rst_seen = 1'b1;
        if (!host_en) chk("rst_bus_released", 64'(bus), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        in_frame = 1'b0; armed = 1'b0; end_slot = 1'b0; busy_run = 0;
        exp_q.delete();
        arm_seen = arm_req;
      end else begin
        rst_seen = 1'b0;
        if (!pinned) begin
          pinned = 1'b1;
          f = frame_of(8'h37, 8'h00, 8'h19, 8'h00, 1'b0);
          chk("model_cksum", 64'(f[7:0]), 64'h50);
          f = frame_of(8'h37, 8'h00, 8'h19, 8'h00, 1'b1);
          chk("model_cksum_inj", 64'(f[7:0]), 64'h51);
          f = frame_of(8'hff, 8'hff, 8'h01, 8'h02, 1'b0);
          chk("model_cksum_wrap", 64'(f[7:0]), 64'h01);
          build_wave(40'h37_00_19_00_50);
          chk("model_wave_len", 64'(exp_q.size()), 64'(3690 * P));
          exp_q.delete();
        end
        if (tmo_req != tmo_seen) begin
          tmo_seen = tmo_req;
          chk("frame_timeout", 64'd0, 64'd1);
        end
        if (arm_req != arm_seen) begin
          arm_seen = arm_req;
          exp_bytes = arm_bytes;
          build_wave(arm_bytes);
          armed = 1'b1; in_frame = 1'b0; pos = 0;
          hi_run = 0; hi_cnt = 0; wire_bits = '0;
        end
        if (end_slot) begin
          end_slot = 1'b0;
          chk("end_frame_done", 64'(frame_done), 64'd1);
          chk("end_busy", 64'(busy), 64'd0);
          chk("end_bus", 64'(bus), 64'd1);
          chk("wire_vs_model", 64'(wire_bits), 64'(exp_bytes));
          if (lit_valid) chk("wire_literal", 64'(wire_bits), 64'(lit_exp));
          frames_done++;
        end else begin
          chk("frame_done_idle", 64'(frame_done), 64'd0);
        end
        if (armed && !in_frame && bus == 1'b0) begin
          chk("resp_dly_busy_cycles", 64'(busy_run), 64'(RespDlyCyc));
          armed = 1'b0; in_frame = 1'b1;
        end
        if (in_frame) begin
          if (bus) hi_run++;
          else if (hi_run > 0) begin
            hi_cnt++;
            if (hi_cnt > 1) wire_bits = {wire_bits[38:0], (hi_run > 48 * P)};
            hi_run = 0;
          end
          e = exp_q.pop_front();
          chk("frame_busy", 64'(busy), 64'd1);
          n_cmp++;
          if (bus !== e) begin
            n_bad++;
            $display("FAIL wave pos %0d: bus %0b expected %0b at %0t", pos, bus, e, $time);
            exp_q.delete();
          end
          pos++;
          if (exp_q.size() == 0) begin
            in_frame = 1'b0;
            end_slot = 1'b1;
          end
        end
        if (quiet) begin
          chk("quiet_busy", 64'(busy), 64'd0);
          if (!host_en) chk("quiet_bus", 64'(bus), 64'd1);
        end
        busy_run = busy ? busy_run + 1 : 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_data(logic [7:0] a, logic [7:0] b, logic [7:0] c, logic [7:0] d,
                          logic inj);
    rh_int = a; rh_dec = b; t_int = c; t_dec = d; inject = inj;
  endtask

  task automatic host_start(int low_us);
    arm_bytes = frame_of(rh_int, rh_dec, t_int, t_dec, inject);
    host_en = 1'b1; host_val = 1'b0;
    cyc(low_us * P);
    host_val = 1'b1;
    arm_req++;
    cyc(20 * P);
    host_en = 1'b0;
  endtask

  task automatic wait_frame(int prev);
    int n;
    n = 0;
    while (frames_done <= prev && n < 12000) begin
      cyc(1);
      n++;
    end
    if (frames_done <= prev) begin
      tmo_req++;
      do_reset();
    end
    cyc(20 * P);
  endtask

  task automatic wait_pos(int target);
    int n;
    n = 0;
    while (pos < target && n < 12000) begin
      cyc(1);
      n++;
    end
    if (pos < target) tmo_req++;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    cyc(4);
    rst = 1'b0;
    cyc(10 * P);
  endtask

  task automatic full_frame(int low_us, logic lv, logic [39:0] le);
    int pd;
    pd = frames_done;
    lit_valid = lv; lit_exp = le;
    host_start(low_us);
    wait_frame(pd);
    lit_valid = 1'b0;
  endtask

  task automatic short_pulse(int low_us);
    quiet = 1'b1;
    host_en = 1'b1; host_val = 1'b0;
    cyc(low_us * P);
    host_en = 1'b0;
    cyc(300 * P);
    quiet = 1'b0;
  endtask

  initial begin
    int pd;
    rst = 1'b1;
    cyc(6);
    rst = 1'b0;
    cyc(20 * P);

    // Reference frame 37/00/19/00 -> checksum 0x50.
    set_data(8'h37, 8'h00, 8'h19, 8'h00, 1'b0);
    full_frame(1900, 1'b1, 40'h37_00_19_00_50);

    // Too-short start pulse: no response.
    short_pulse(500);

    // Checksum fault injection.
    set_data(8'h37, 8'h00, 8'h19, 8'h00, 1'b1);
    full_frame(1200, 1'b1, 40'h37_00_19_00_51);
    inject = 1'b0;

    // Reset during bit 20 low phase, then a clean frame.
    pd = frames_done;
    host_start(1200);
    wait_pos(bit_start(arm_bytes, 20) + 10);
    do_reset();
    full_frame(1200, 1'b1, 40'h37_00_19_00_50);

    // Data change mid-frame does not affect the frame in flight.
    pd = frames_done;
    lit_valid = 1'b1; lit_exp = 40'h37_00_19_00_50;
    host_start(1200);
    wait_pos(bit_start(arm_bytes, 5) + 10);
    rh_int = 8'h42;
    wait_frame(pd);
    lit_valid = 1'b0;

    // Randomized frames and short pulses.
    for (int i = 0; i < 2; i++) begin
      set_data(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
               1'($urandom_range(0, 1)));
      full_frame(int'($urandom_range(1100, 1400)), 1'b0, '0);
      short_pulse(int'($urandom_range(100, 900)));
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
